// File: rtl/mant_div_if.sv
// mant_div_if -- operand/result handshake bundle for the mantissa divider.
//   in_valid/in_ready    : operand handshake (dividend, divisor)
//   out_valid/out_ready  : result handshake (quotient, remainder, div_by_zero)
//   master : producer/consumer side (testbench or surrounding FPU)
//   slave  : divider side
interface mant_div_if #(
    parameter int W = 33
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/mant_div.sv
// mant_div -- unsigned W-bit divider, radix-2 non-restoring, one quotient
// bit per cycle.
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : mant_div_if.slave
//         in  : in_valid, dividend, divisor, out_ready
//         out : in_ready (IDLE only), out_valid (DONE only),
//               quotient, remainder, div_by_zero (all registered)
// A zero divisor skips the iteration and returns quotient = all ones,
// remainder = dividend, div_by_zero = 1.
module mant_div #(
    parameter int W = 33
) (
    input  logic     clk,
    input  logic     rst,
    mant_div_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [W+1:0]  p;        // partial remainder, two's complement, sign = p[W+1]
    logic [W-1:0]  q;        // dividend shifting out, quotient bits shifting in
    logic [W-1:0]  d;        // registered divisor
    logic          dbz;

    logic [W+1:0]  d_ext;
    logic [W+1:0]  p_shift;
    logic [W+1:0]  p_step;
    logic [W-1:0]  q_step;
    logic          last;

    assign last = (cnt == CW'(W - 1));

    // One non-restoring step: shift {P,Q} left, add or subtract D by the old
    // sign of P, and shift in the complement of the new sign as quotient bit.
    always_comb begin
        d_ext   = {2'b00, d};
        p_shift = {p[W:0], q[W-1]};
        p_step  = p[W+1] ? (p_shift + d_ext) : (p_shift - d_ext);
        q_step  = {q[W-2:0], ~p_step[W+1]};
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nxt = (bus.divisor == '0) ? DONE : CALC;
            CALC:    if (last) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            p   <= '0;
            q   <= '0;
            d   <= '0;
            dbz <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        d   <= bus.divisor;
                        cnt <= '0;
                        if (bus.divisor == '0) begin
                            q   <= '1;
                            p   <= {2'b00, bus.dividend};
                            dbz <= 1'b1;
                        end else begin
                            q   <= bus.dividend;
                            p   <= '0;
                            dbz <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    p   <= p_step;
                    q   <= q_step;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    // final restore so the remainder lands in [0, D)
                    if (p[W+1]) p <= p + d_ext;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.quotient    = q;
    assign bus.remainder   = p[W-1:0];
    assign bus.div_by_zero = dbz;
endmodule
